// File: rtl/raptor_pkg.sv
// Shared types and constants for the raptor memory-side blocks.
package raptor_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Plain 2:1 word mux used on the arbiter address path.
module mem_port_arbiter_mux
    import raptor_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and LSU (port 1),
// with a per-transfer timeout that aborts a stalled request.
module mem_port_arbiter
    import raptor_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] addr0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0] wdata1_i,
    input  logic             we1_i,
    output logic             done0_o,
    output logic             done1_o,
    output logic             err0_o,
    output logic             err1_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             mem_valid_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic             mem_we_o,
    input  logic             mem_ready_i,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] mux_addr;
    logic             timeout_hit;

    mem_port_arbiter_mux #(.WIDTH(WIDTH)) u_addr_mux (
        .sel_i (sel_q),
        .in0_i (addr0_i),
        .in1_i (addr1_i),
        .y_o   (mux_addr)
    );

    assign timeout_hit = (TIMEOUT > 0) && (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            timer_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        timer_d = timer_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = BUSY;
                    timer_d = '0;
                    sel_d   = (req0_i && req1_i) ? ~last_q : req1_i;
                end
            end
            BUSY: begin
                // a completion on the expiry cycle takes priority over the abort
                if (mem_ready_i) begin
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    rdata_d = mem_rdata_i;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    err0_d  = ~sel_q;
                    err1_d  = sel_q;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_valid_o = (state_q == BUSY);
        mem_addr_o  = mem_valid_o ? mux_addr : '0;
        mem_wdata_o = (mem_valid_o && sel_q) ? wdata1_i : '0;
        mem_we_o    = mem_valid_o && sel_q && we1_i;
    end

    assign done0_o = done0_q;
    assign done1_o = done1_q;
    assign err0_o  = err0_q;
    assign err1_o  = err1_q;
    assign rdata_o = rdata_q;

endmodule
